io_input_port: RTL
==================

# io_input_port

Memory-mapped input block for the single-cycle computer. It samples the two 5-bit switch ports (`in_port0`, `in_port1`), synchronizes and debounces them, and presents them as zero-extended 32-bit words on the data-memory IO read path (`io_read_data`). A sticky change-status register lets software poll for new switch values. It is the read-side counterpart of the output-port and seven-segment path.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles a synchronized input must differ from the stable value before it is accepted. Legal range is 2..65535.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_port0`  in  5: raw switch input, port 0; asynchronous to `clock`.
- `in_port1`  in  5: raw switch input, port 1; asynchronous to `clock`.
- `addr`  in  32: CPU data address (ALU output).
- `rd_en`  in  1: CPU load strobe for the IO region; one cycle per load.
- `io_read_data`  out  32: read data, combinational from registered state.
- `changed`  out  1: OR of the status sticky bits; registered.

## Operation
- **Address map.** Decode uses `addr[7:0]` only. 0x80 returns `{27'b0, stable0}`. 0x84 returns `{27'b0, stable1}`. 0x88 returns `{30'b0, chg1, chg0}`. Any other address returns 0. The decode ignores `rd_en`.
- **Synchronizer.** Each port passes through a 2-flop synchronizer: `raw -> s1 -> s2`.
- **Debounce, per port.** Each port has a 16-bit counter `cnt` and a register `stable`.
  - If `s2 == stable`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2`, `cnt <= 0`, and `chg <= 1`.
  - Otherwise, `cnt <= cnt+1`.
  - Any bounce back to `stable` restarts the count.
  - A different new value mid-count does not restart the count. The value accepted is whatever `s2` holds on the accepting cycle.
- **Status clear.** On an edge where `rd_en` is high and `addr[7:0] == 0x88`, both `chg` bits clear. That same read returns the pre-clear value.
- **Set and clear in the same edge.** The set wins, so the bit stays 1.
- **Independence.** Both ports run independently and can update on the same cycle.
- **Reset values.** Asynchronous reset drives all state to 0: `s1`, `s2`, `stable`, `cnt`, `chg`, and `changed`. `io_read_data` therefore reads 0 at every address.
- **Reset mid-debounce.** A reset during a debounce discards the pending count. After release the port re-acquires from scratch; this includes switches that were held non-zero through the reset.

## Timing
- **Latency.** From a raw input change to `stable` updating:
  - 2 cycles for synchronization.
  - Then DEBOUNCE_CYCLES cycles of mismatch, provided the input is steady.
  - Total: DEBOUNCE_CYCLES+2 edges.
- **Status timing.** `chg` sets on the same edge that `stable` updates. `changed` follows one edge later.
- **Read timing.** `io_read_data` is valid in the same cycle that `addr` is valid, which suits single-cycle loads.
- **Counter width.** `cnt` is 16 bits and never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

## Configuration
- `IO_INPUT_DEBOUNCE_EN` defined: debounce operates as described above.
- `IO_INPUT_DEBOUNCE_EN` undefined:
  - The counters are removed and `stable <= s2` every cycle.
  - `chg` sets on any edge where `s2 != stable`.
  - Latency is 3 edges.
  - `DEBOUNCE_CYCLES` is ignored.
  - The address map and status behaviour are unchanged.

## Test plan
1. **Reset.** Hold `resetn` = 0 with `in_port0` = 5'h1F. Expect `io_read_data` = 0 at 0x80, 0x84 and 0x88, and `changed` = 0. Release reset with `DEBOUNCE_CYCLES` = 16. Expect 0x80 to read 0x1F after 18 edges and `chg0` = 1.
2. **Clean change.** Set `in_port1` to 5'h0A and hold it. Expect 0x84 to read 0 through edge 17 and 0x0A at edge 18. Expect status = 2'b10 and `changed` = 1 one edge later.
3. **Bounce.** Toggle `in_port0` between 5'h03 and 5'h00 every 5 cycles for 100 cycles, then settle at 5'h03. Expect `stable0` to stay 0 throughout the toggling and `chg0` to stay 0. Expect 0x03 exactly 18 edges after settling.
4. **Status read and clear.** With status = 2'b11, read 0x88 with `rd_en` = 1. Expect the read to return 3, status to be 0 after the edge, and `changed` to be 0 one edge later. Repeat with a port-0 acceptance on the same edge as the clear: expect status = 2'b01.
5. **Reset mid-debounce.** Change `in_port0` to 5'h11 and assert `resetn` = 0 at count 10. Release reset. Expect `stable0` = 0 until 18 edges after release, then 0x11.
6. **Unmapped address.** Read `addr` = 0x8C and 0x00 with non-zero stable values. Expect `io_read_data` = 0 and the status bits unchanged.

Source files
------------

// File: rtl/io_input_port_if.sv
// CPU-side IO read bus for io_input_port: load address/strobe in, read data and
// change flag out.
interface io_input_port_if;
  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] io_read_data;
  logic        changed;

  modport master (
    output addr,
    output rd_en,
    input  io_read_data,
    input  changed
  );

  modport slave (
    input  addr,
    input  rd_en,
    output io_read_data,
    output changed
  );
endinterface

// File: rtl/io_input_port.sv
// Memory-mapped switch input block: 2-flop sync, per-port debounce, sticky change status.
// Define IO_INPUT_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES counters; otherwise stable tracks s2 directly.
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [4:0]      in_port0,
  input  logic [4:0]      in_port1,
  io_input_port_if.slave  bus
);

  localparam logic [7:0] ADDR_PORT0  = 8'h80;
  localparam logic [7:0] ADDR_PORT1  = 8'h84;
  localparam logic [7:0] ADDR_STATUS = 8'h88;

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_cfg
    $error("io_input_port: DEBOUNCE_CYCLES out of range 2..65535");
  end

  logic [1:0][4:0] raw_s;
  logic [1:0][4:0] stable_s;
  logic [1:0]      accept_s;
  logic [1:0]      chg_r;
  logic            changed_r;
  logic            clear_s;
  logic [31:0]     read_data_s;
  logic            unused_addr_s;

  assign raw_s[0] = in_port0;
  assign raw_s[1] = in_port1;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [4:0] s1_r;
    logic [4:0] s2_r;
    logic [4:0] stable_r;
    logic [4:0] stable_nxt_s;
    logic       accept_nxt_s;

    // two-flop synchronizer for the asynchronous switch input
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        s1_r <= 5'd0;
        s2_r <= 5'd0;
      end else begin
        s1_r <= raw_s[p];
        s2_r <= s1_r;
      end
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;

    // debounce: count consecutive mismatch cycles; a bounce back to stable restarts
    always_comb begin
      cnt_nxt_s    = cnt_r;
      stable_nxt_s = stable_r;
      accept_nxt_s = 1'b0;
      if (s2_r == stable_r) begin
        cnt_nxt_s = 16'd0;
      end else if (cnt_r == LAST_CNT) begin
        stable_nxt_s = s2_r;
        cnt_nxt_s    = 16'd0;
        accept_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + 16'd1;
      end
    end

    // debounce counter register
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_nxt_s;
      end
    end
`else
    // no debounce: accept the synchronized value on every edge it differs
    always_comb begin
      stable_nxt_s = s2_r;
      accept_nxt_s = 1'b0;
      if (s2_r != stable_r) begin
        accept_nxt_s = 1'b1;
      end else begin
        accept_nxt_s = 1'b0;
      end
    end
`endif

    // accepted switch value register
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        stable_r <= 5'd0;
      end else begin
        stable_r <= stable_nxt_s;
      end
    end

    assign stable_s[p] = stable_r;
    assign accept_s[p] = accept_nxt_s;
  end

  assign clear_s = bus.rd_en && (bus.addr[7:0] == ADDR_STATUS);

  // sticky change bits; a same-edge acceptance beats the read-clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chg_r <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (accept_s[p]) begin
          chg_r[p] <= 1'b1;
        end else if (clear_s) begin
          chg_r[p] <= 1'b0;
        end else begin
          chg_r[p] <= chg_r[p];
        end
      end
    end
  end

  // registered summary flag, one edge behind the sticky bits
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      changed_r <= 1'b0;
    end else begin
      changed_r <= |chg_r;
    end
  end

  // read mux decodes only the low address byte and ignores rd_en
  always_comb begin
    read_data_s = 32'd0;
    case (bus.addr[7:0])
      ADDR_PORT0:  read_data_s = {27'd0, stable_s[0]};
      ADDR_PORT1:  read_data_s = {27'd0, stable_s[1]};
      ADDR_STATUS: read_data_s = {30'd0, chg_r};
      default:     read_data_s = 32'd0;
    endcase
  end

  assign bus.io_read_data = read_data_s;
  assign bus.changed      = changed_r;
  assign unused_addr_s    = ^bus.addr[31:8];

endmodule
